d_cache_v2: RTL and testbench
=============================

# d_cache_v2

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core load/store unit and the backing data memory bus. Successor to the single-bank byte-strobe data RAM: configurable line count and words per line, tag/valid lookup, a refill state machine with a valid/ready core handshake, flush, and strobe-error reporting. Store data keeps the core's right-aligned convention and is lane-steered internally.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINES, 64, number of lines (power of two, ≥2)
- WORDS, 4, 32-bit words per line (power of two, ≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- core_req  in  1  request valid
- core_ready  out  1  request accepted when core_req && core_ready
- core_we  in  1  1 = store, 0 = load
- core_wstrb  in  4  byte-lane strobe (stores only)
- core_addr  in  ADDR_W  byte address; bits [1:0] ignored
- core_wdata  in  32  right-aligned store data
- core_done  out  1  one-cycle completion pulse
- core_rdata  out  32  load data, valid with core_done
- core_err  out  1  illegal strobe, valid with core_done
- flush  in  1  invalidate all lines
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned bus address
- mem_wstrb  out  4  bus strobe
- mem_wdata  out  32  lane-steered bus write data
- mem_ack  in  1  bus beat complete
- mem_rdata  in  32  bus read data, valid with mem_ack

## Operation
- Address split: offset = addr[1:0], word = next log2(WORDS) bits, index = next log2(LINES) bits, tag = remainder.
- Storage: data array LINES×WORDS×32, tag array, valid bit per line (flops; valid cleared by reset).
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE: core_ready=1. Accept registers addr/we/wstrb/wdata → LOOKUP.
- LOOKUP, load hit: core_rdata = array word, → RESP.
- LOOKUP, load miss: → REFILL; beats word 0..WORDS-1 of the line, mem_addr = {tag,index,beat,2'b00}; each beat written into the array on mem_ack; after last beat set tag and valid → RESP with requested word.
- LOOKUP, store, legal strobe: → WRITE; mem_req/mem_we held until mem_ack; on hit the array word is byte-merged in the ack cycle; miss leaves the cache untouched → RESP.
- LOOKUP, store, illegal strobe: no bus or array activity, core_err=1 → RESP.
- Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Steering: single byte from wdata[7:0] to selected lane; halfword from wdata[15:0] to lanes 1:0 or 3:2; word unchanged.
- RESP: core_done=1 one cycle → IDLE.
- Flush: in IDLE clears all valid bits the same cycle and blocks acceptance (core_ready=0) that cycle; asserted while busy it is latched and applied on the first IDLE cycle.

## Timing
- Reset: state IDLE, all valid 0, core_ready 1; core_done, core_err, mem_req, mem_we 0; core_rdata, mem_addr, mem_wstrb, mem_wdata 0.
- Load hit: accept cycle N, core_done at N+2.
- Load miss: core_done 2 cycles after the last mem_ack.
- Store: core_done 2 cycles after mem_ack; illegal strobe: done+err at N+2.
- mem_* outputs stable while mem_req=1; mem_ack while mem_req=0 ignored.
- core_rdata holds its value until the next load completes.
- Reset asserted mid-refill: line stays invalid, bus request dropped immediately.

## Configuration
- D_CACHE_STATS_EN defined: 32-bit saturating counters hit_cnt, miss_cnt, err_cnt exported as outputs, cleared by reset only; load hits count as hits, load misses as misses; stores count as neither.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Package d_cache_pkg: state enum, legal-strobe constants, strobe-check and lane-steer functions.
- Sub-module d_cache_steer: combinational strobe validation plus byte/halfword lane steering and merge; top holds arrays and FSM.

## Test plan
- Reset, then load 0x100 (miss, WORDS=4): four beats 0x100..0x10C, core_rdata = mem word 0x100, next load 0x104 hits with done at N+2, no mem_req.
- Store wstrb 0010, wdata 0x000000AB to cached 0x100 holding 0x11223344: mem_wdata 0x0000AB00, later load returns 0x1122AB44.
- Store wstrb 0101: core_err=1 with done at N+2, mem_req never asserted, cached data unchanged.
- Conflict: load 0x100 then load 0x100+LINES*WORDS*4 → second misses and refills; reload 0x100 misses again.
- Flush asserted during a refill: refill completes, first IDLE cycle clears valids with core_ready=0; the same address reloaded misses.
- Reset asserted between beats 2 and 3: mem_req drops immediately, line invalid, post-reset load misses.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the d_cache_v2 data cache: FSM states,
// legal store strobes, and the byte-lane steering/merge functions.
package d_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESP
    } state_t;

    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b1100;
    localparam logic [3:0] STRB_W  = 4'b1111;

    function automatic logic isLegalStrobe(input logic [3:0] strb);
        return strb inside {STRB_B0, STRB_B1, STRB_B2, STRB_B3, STRB_H0, STRB_H1, STRB_W};
    endfunction

    // Store data arrives right-aligned; move the byte/halfword onto its lanes.
    function automatic logic [31:0] steerData(input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] res;
        res = '0;
        case (strb)
            STRB_B0: res = {24'h0, data[7:0]};
            STRB_B1: res = {16'h0, data[7:0], 8'h0};
            STRB_B2: res = {8'h0, data[7:0], 16'h0};
            STRB_B3: res = {data[7:0], 24'h0};
            STRB_H0: res = {16'h0, data[15:0]};
            STRB_H1: res = {data[15:0], 16'h0};
            STRB_W:  res = data;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] oldWord,
                                              input logic [31:0] laneData,
                                              input logic [3:0]  strb);
        logic [31:0] res;
        res = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = laneData[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/d_cache_v2_if.sv
// Core-side and memory-bus-side signal bundles for d_cache_v2.
// The cache is the slave of the core interface and the master of the bus.
interface d_cache_core_if #(parameter int ADDR_W = 32);
    logic              core_req;
    logic              core_ready;
    logic              core_we;
    logic [3:0]        core_wstrb;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_done;
    logic [31:0]       core_rdata;
    logic              core_err;
    logic              flush;

    modport master (
        output core_req, core_we, core_wstrb, core_addr, core_wdata, flush,
        input  core_ready, core_done, core_rdata, core_err
    );

    modport slave (
        input  core_req, core_we, core_wstrb, core_addr, core_wdata, flush,
        output core_ready, core_done, core_rdata, core_err
    );
endinterface

interface d_cache_mem_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/d_cache_steer.sv
// Combinational store path: strobe legality, lane steering of right-aligned
// store data, and byte merge into the currently cached word.
module d_cache_steer
    import d_cache_pkg::*;
(
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_oldWord,
    output logic        o_legal,
    output logic [31:0] o_laneData,
    output logic [31:0] o_merged
);

    assign o_legal    = isLegalStrobe(i_wstrb);
    assign o_laneData = steerData(i_wstrb, i_wdata);
    assign o_merged   = mergeWord(i_oldWord, o_laneData, i_wstrb);

endmodule

// File: rtl/d_cache_v2.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill.
// Optional feature macro D_CACHE_STATS_EN adds saturating hit/miss/error counters.
module d_cache_v2
    import d_cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINES  = 64,
    parameter int WORDS  = 4
) (
    input logic           clk,
    input logic           rst,
    d_cache_core_if.slave core,
    d_cache_mem_if.master mem
`ifdef D_CACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt,
    output logic [31:0]   err_cnt
`endif
);

    localparam int WBITS   = $clog2(WORDS);
    localparam int IBITS   = $clog2(LINES);
    localparam int LINE_SH = 2 + WBITS;
    localparam int TAG_SH  = LINE_SH + IBITS;
    localparam int TAG_W   = ADDR_W - TAG_SH;
    localparam int WIDX_W  = (WORDS > 1) ? WBITS : 1;
    localparam logic [WIDX_W-1:0] LAST_BEAT = WIDX_W'(WORDS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [WIDX_W-1:0] r_beat;
    logic              r_busDone;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_flushPend;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES][WORDS];

    logic [IBITS-1:0]  w_index;
    logic [WIDX_W-1:0] w_word;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_lineBase;
    logic              w_hit;
    logic [31:0]       w_curWord;
    logic              w_legal;
    logic [31:0]       w_laneData;
    logic [31:0]       w_merged;
    logic              w_flushNow;
    logic              w_lastBeat;

    assign w_index    = IBITS'(r_addr >> LINE_SH);
    assign w_word     = WIDX_W'((r_addr >> 2) & ADDR_W'(WORDS - 1));
    assign w_tag      = TAG_W'(r_addr >> TAG_SH);
    assign w_lineBase = (r_addr >> LINE_SH) << LINE_SH;
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_curWord  = r_data[w_index][w_word];
    assign w_flushNow = core.flush || r_flushPend;
    assign w_lastBeat = (r_beat == LAST_BEAT);

    d_cache_steer u_steer (
        .i_wstrb    (r_wstrb),
        .i_wdata    (r_wdata),
        .i_oldWord  (w_curWord),
        .o_legal    (w_legal),
        .o_laneData (w_laneData),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Bus transactions return through LOOKUP with r_busDone set, giving the
    // two-cycle ack-to-done latency and a single place that loads r_rdata.
    always_comb begin
        w_next          = r_state;
        core.core_ready = 1'b0;
        core.core_done  = 1'b0;
        core.core_err   = 1'b0;
        core.core_rdata = r_rdata;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_addr    = '0;
        mem.mem_wstrb   = '0;
        mem.mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                core.core_ready = !w_flushNow;
                if (!w_flushNow && core.core_req) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (r_busDone)  w_next = RESP;
                else if (!r_we) w_next = w_hit ? RESP : REFILL;
                else            w_next = w_legal ? WRITE : RESP;
            end
            REFILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = w_lineBase | (ADDR_W'(r_beat) << 2);
                if (mem.mem_ack && w_lastBeat) w_next = LOOKUP;
            end
            WRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                mem.mem_wstrb = r_wstrb;
                mem.mem_wdata = w_laneData;
                if (mem.mem_ack) w_next = LOOKUP;
            end
            RESP: begin
                core.core_done = 1'b1;
                core.core_err  = r_err;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_busDone   <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_flushPend <= 1'b0;
            r_valid     <= '0;
        end else begin
            if (r_state != IDLE && core.flush) r_flushPend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_flushNow) begin
                        r_valid     <= '0;
                        r_flushPend <= 1'b0;
                    end else if (core.core_req) begin
                        r_addr    <= core.core_addr;
                        r_we      <= core.core_we;
                        r_wstrb   <= core.core_wstrb;
                        r_wdata   <= core.core_wdata;
                        r_beat    <= '0;
                        r_busDone <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (!r_we && (r_busDone || w_hit)) r_rdata <= w_curWord;
                    if (r_we && !r_busDone && !w_legal) r_err <= 1'b1;
                end
                REFILL: begin
                    if (mem.mem_ack) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_lastBeat) begin
                            r_valid[w_index] <= 1'b1;
                            r_busDone        <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) r_busDone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data and tags need no reset: the valid bits alone decide hits.
    always_ff @(posedge clk) begin
        case (r_state)
            REFILL: begin
                if (mem.mem_ack) begin
                    r_data[w_index][r_beat] <= mem.mem_rdata;
                    if (w_lastBeat) r_tag[w_index] <= w_tag;
                end
            end
            WRITE: begin
                if (mem.mem_ack && w_hit) r_data[w_index][w_word] <= w_merged;
            end
            default: ;
        endcase
    end

`ifdef D_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            err_cnt  <= '0;
        end else if (r_state == LOOKUP && !r_busDone) begin
            if (!r_we) begin
                if (w_hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                end
            end else if (!w_legal) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_d_cache_v2.sv
// Scoreboard bench for d_cache_v2: directed loads/stores against a bus
// responder model; a negedge monitor pops expected responses on core_done.
module tb_d_cache_v2;

    localparam int ADDR_W   = 32;
    localparam int LINES    = 64;
    localparam int WORDS    = 4;
    localparam int KIND_HIT = 0;
    localparam int KIND_BUS = 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          kind;
        int          acceptCycle;
    } sbEntry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    d_cache_core_if #(.ADDR_W(ADDR_W)) coreIf();
    d_cache_mem_if  #(.ADDR_W(ADDR_W)) memIf();

`ifdef D_CACHE_STATS_EN
    logic [31:0] hitCnt, missCnt, errCnt;
`endif

    d_cache_v2 #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (coreIf),
        .mem  (memIf)
`ifdef D_CACHE_STATS_EN
        ,
        .hit_cnt  (hitCnt),
        .miss_cnt (missCnt),
        .err_cnt  (errCnt)
`endif
    );

    initial forever #5 clk = ~clk;

    int          cyc = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    int          reqCycles = 0;
    int          lastAckCycle = -100;
    bit          stallBus = 1'b0;
    bit          ackGap = 1'b0;
    sbEntry_t    sbQ[$];
    logic [31:0] beatLog[$];
    logic [31:0] wrAddrLog[$];
    logic [31:0] wrDataLog[$];
    logic [3:0]  wrStrbLog[$];
    logic [31:0] memArr [logic [31:0]];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    // Bus responder: acks every other cycle while mem_req is high.
    initial begin
        logic [31:0] word;
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = '0;
        forever begin
            @(negedge clk);
            memIf.mem_ack = 1'b0;
            if (!rst && memIf.mem_req) begin
                reqCycles++;
                if (!ackGap && !stallBus) begin
                    memIf.mem_ack = 1'b1;
                    lastAckCycle  = cyc;
                    if (memIf.mem_we) begin
                        word = memRead(memIf.mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (memIf.mem_wstrb[i]) word[8*i +: 8] = memIf.mem_wdata[8*i +: 8];
                        memArr[memIf.mem_addr] = word;
                        wrAddrLog.push_back(memIf.mem_addr);
                        wrDataLog.push_back(memIf.mem_wdata);
                        wrStrbLog.push_back(memIf.mem_wstrb);
                    end else begin
                        memIf.mem_rdata = memRead(memIf.mem_addr);
                        beatLog.push_back(memIf.mem_addr);
                    end
                    ackGap = 1'b1;
                end else begin
                    ackGap = 1'b0;
                end
            end else begin
                ackGap = 1'b0;
            end
        end
    end

    // Monitor: every completion must match the oldest expected response.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            if (!rst && coreIf.core_done) begin
                if (sbQ.size() == 0) begin
                    failNow("unexpected core_done");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, "_rdata"}, coreIf.core_rdata, e.rdata);
                    checkOutput({e.name, "_err"}, {31'b0, coreIf.core_err}, {31'b0, e.err});
                    if (e.kind == KIND_HIT)
                        checkOutput({e.name, "_latency"}, 32'(cyc - e.acceptCycle), 32'd2);
                    else
                        checkOutput({e.name, "_ack_to_done"}, 32'(cyc - lastAckCycle), 32'd2);
                end
            end
        end
    end

    task automatic waitQueueEmpty(input string name);
        int n = 0;
        while (sbQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            failNow({name, " timeout waiting for core_done"});
            sbQ.delete();
        end
    endtask

    task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                                 input logic [3:0] strb, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int kind, input bit doWait);
        sbEntry_t e;
        int n = 0;
        @(negedge clk);
        while (!coreIf.core_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!coreIf.core_ready) begin
            failNow({name, " timeout waiting for core_ready"});
            return;
        end
        coreIf.core_req   = 1'b1;
        coreIf.core_we    = we;
        coreIf.core_addr  = addr;
        coreIf.core_wstrb = strb;
        coreIf.core_wdata = wdata;
        e.name        = name;
        e.rdata       = expRdata;
        e.err         = expErr;
        e.kind        = kind;
        e.acceptCycle = cyc;
        sbQ.push_back(e);
        @(negedge clk);
        coreIf.core_req = 1'b0;
        if (doWait) waitQueueEmpty(name);
    endtask

    task automatic waitBeats(input int target);
        int n = 0;
        while (beatLog.size() < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (beatLog.size() < target) failNow("timeout waiting for refill beats");
    endtask

    initial begin
        int base;
        int reqBase;
        int wrBase;

        coreIf.core_req   = 1'b0;
        coreIf.core_we    = 1'b0;
        coreIf.core_wstrb = '0;
        coreIf.core_addr  = '0;
        coreIf.core_wdata = '0;
        coreIf.flush      = 1'b0;
        memArr[32'h100] = 32'h11223344;
        memArr[32'h104] = 32'h55667788;
        memArr[32'h108] = 32'h99AABBCC;
        memArr[32'h10C] = 32'hDDEEFF00;
        memArr[32'h500] = 32'hDEAD0500;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_core_ready", {31'b0, coreIf.core_ready}, 32'd1);
        checkOutput("reset_core_done",  {31'b0, coreIf.core_done},  32'd0);
        checkOutput("reset_core_err",   {31'b0, coreIf.core_err},   32'd0);
        checkOutput("reset_core_rdata", coreIf.core_rdata, 32'h0);
        checkOutput("reset_mem_req",    {31'b0, memIf.mem_req}, 32'd0);
        checkOutput("reset_mem_we",     {31'b0, memIf.mem_we},  32'd0);
        checkOutput("reset_mem_addr",   memIf.mem_addr, 32'h0);
        checkOutput("reset_mem_wstrb",  {28'b0, memIf.mem_wstrb}, 32'h0);
        checkOutput("reset_mem_wdata",  memIf.mem_wdata, 32'h0);
        rst = 1'b0;

        base = beatLog.size();
        applyStimulus("load_miss_100", 1'b0, 32'h100, 4'h0, 32'h0, 32'h11223344, 1'b0, KIND_BUS, 1'b1);
        checkOutput("miss_beat_count", 32'(beatLog.size() - base), 32'd4);
        checkOutput("miss_beat0", beatLog[base],     32'h100);
        checkOutput("miss_beat1", beatLog[base + 1], 32'h104);
        checkOutput("miss_beat2", beatLog[base + 2], 32'h108);
        checkOutput("miss_beat3", beatLog[base + 3], 32'h10C);

        reqBase = reqCycles;
        applyStimulus("load_hit_104", 1'b0, 32'h104, 4'h0, 32'h0, 32'h55667788, 1'b0, KIND_HIT, 1'b1);
        checkOutput("hit_no_mem_req", 32'(reqCycles - reqBase), 32'd0);

        wrBase = wrAddrLog.size();
        applyStimulus("store_b1", 1'b1, 32'h100, 4'b0010, 32'h000000AB, 32'h55667788, 1'b0, KIND_BUS, 1'b1);
        checkOutput("store_write_count", 32'(wrAddrLog.size() - wrBase), 32'd1);
        checkOutput("store_mem_addr",  wrAddrLog[wrBase], 32'h100);
        checkOutput("store_mem_wdata", wrDataLog[wrBase], 32'h0000AB00);
        checkOutput("store_mem_wstrb", {28'b0, wrStrbLog[wrBase]}, 32'h2);

        applyStimulus("load_after_store", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122AB44, 1'b0, KIND_HIT, 1'b1);

        reqBase = reqCycles;
        applyStimulus("store_illegal", 1'b1, 32'h100, 4'b0101, 32'hFFFFFFFF, 32'h1122AB44, 1'b1, KIND_HIT, 1'b1);
        checkOutput("illegal_no_mem_req", 32'(reqCycles - reqBase), 32'd0);
        applyStimulus("load_after_illegal", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122AB44, 1'b0, KIND_HIT, 1'b1);

        base = beatLog.size();
        applyStimulus("conflict_load_500", 1'b0, 32'h500, 4'h0, 32'h0, 32'hDEAD0500, 1'b0, KIND_BUS, 1'b1);
        checkOutput("conflict_beat_count", 32'(beatLog.size() - base), 32'd4);
        checkOutput("conflict_beat0", beatLog[base], 32'h500);
        base = beatLog.size();
        applyStimulus("conflict_reload_100", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122AB44, 1'b0, KIND_BUS, 1'b1);
        checkOutput("reload_beat_count", 32'(beatLog.size() - base), 32'd4);

        base = beatLog.size();
        applyStimulus("flush_during_refill", 1'b0, 32'h500, 4'h0, 32'h0, 32'hDEAD0500, 1'b0, KIND_BUS, 1'b0);
        waitBeats(base + 1);
        @(negedge clk);
        coreIf.flush = 1'b1;
        @(negedge clk);
        coreIf.flush = 1'b0;
        waitQueueEmpty("flush_during_refill");
        @(negedge clk);
        checkOutput("flush_first_idle_ready", {31'b0, coreIf.core_ready}, 32'd0);
        base = beatLog.size();
        applyStimulus("load_after_flush", 1'b0, 32'h500, 4'h0, 32'h0, 32'hDEAD0500, 1'b0, KIND_BUS, 1'b1);
        checkOutput("flush_reload_beats", 32'(beatLog.size() - base), 32'd4);

        base = beatLog.size();
        applyStimulus("load_reset_mid", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122AB44, 1'b0, KIND_BUS, 1'b0);
        waitBeats(base + 2);
        stallBus = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("reset_mid_mem_req",    {31'b0, memIf.mem_req}, 32'd0);
        checkOutput("reset_mid_core_ready", {31'b0, coreIf.core_ready}, 32'd1);
        checkOutput("reset_mid_core_rdata", coreIf.core_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stallBus = 1'b0;
        base = beatLog.size();
        applyStimulus("load_post_reset", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122AB44, 1'b0, KIND_BUS, 1'b1);
        checkOutput("post_reset_beats", 32'(beatLog.size() - base), 32'd4);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired after %0d tests", testsRun);
        $fatal(1, "[TB] watchdog");
    end

endmodule
